// File: rtl/photonic_pkg.sv
// photonic_pkg: shared widths, loader state encoding and frame length for the W serial link.
// Frame length grows by one parity bit when W_LOADER_PARITY_EN is defined.
package photonic_pkg;
  localparam int W_WIDTH_DEFAULT = 13;
  typedef enum logic {IDLE, SHIFT} ld_state_e;
  function automatic int frame_bits(input int w);
`ifdef W_LOADER_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction
endpackage

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep flop synchroniser with a configurable reset level.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s_q, s_d;
  always_comb s_d = {s_q[STAGES-2:0], d};
  always_ff @(posedge clk) s_q <= reset ? {STAGES{RST_VAL}} : s_d;
  assign q = s_q[STAGES-1];
endmodule

// File: rtl/w_serial_loader.sv
// w_serial_loader: three-wire serial receiver committing validated W words to a held register.
// Define W_LOADER_PARITY_EN to append and check an odd parity bit on every frame.
module w_serial_loader
  import photonic_pkg::*;
#(
  parameter int W_WIDTH     = W_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sclk,
  input  logic               sdata,
  input  logic               cs_n,
  output logic [W_WIDTH-1:0] W,
  output logic               W_valid,
  output logic               frame_err,
  output logic               busy
);
  localparam int FB = frame_bits(W_WIDTH);
  localparam int CW = $clog2(FB + 2);
  ld_state_e    state_q, state_d;
  logic [FB-1:0] shreg_q, shreg_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [W_WIDTH-1:0] w_q, w_d;
  logic w_valid_q, w_valid_d, frame_err_q, frame_err_d;
  logic sclk_h_q, cs_h_q, sdata_h_q;
  logic sclk_s, sdata_s, cs_s;
  logic sclk_rise, cs_fall, cs_rise, par_ok, good;
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk  (.clk, .reset, .d(sclk),  .q(sclk_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdata (.clk, .reset, .d(sdata), .q(sdata_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs    (.clk, .reset, .d(cs_n),  .q(cs_s));
  assign sclk_rise = sclk_s & ~sclk_h_q;
  assign cs_fall   = ~cs_s & cs_h_q;
  assign cs_rise   = cs_s & ~cs_h_q;
`ifdef W_LOADER_PARITY_EN
  assign par_ok = ^shreg_q;
`else
  assign par_ok = 1'b1;
`endif
  assign good = (bit_cnt_q == CW'(FB)) && par_ok;
  // cs_n rise outranks a coincident sclk rise, so that bit never lands in shreg
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    w_d         = w_q;
    w_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (en && cs_fall) begin
        state_d   = SHIFT;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
    end else if (!en) begin
      state_d = IDLE;
    end else if (cs_rise) begin
      state_d     = IDLE;
      w_d         = good ? shreg_q[FB-1 -: W_WIDTH] : w_q;
      w_valid_d   = good;
      frame_err_d = ~good;
    end else if (sclk_rise) begin
      shreg_d   = {shreg_q[FB-2:0], sdata_s};
      bit_cnt_d = (bit_cnt_q == CW'(FB + 1)) ? bit_cnt_q : bit_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      w_q         <= '0;
      w_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      sclk_h_q    <= 1'b0;
      sdata_h_q   <= 1'b0;
      cs_h_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      frame_err_q <= frame_err_d;
      sclk_h_q    <= sclk_s;
      sdata_h_q   <= sdata_s;
      cs_h_q      <= cs_s;
    end
  end
  assign W         = w_q;
  assign W_valid   = w_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == SHIFT) && !sdata_h_q && 1'b1 || (state_q == SHIFT);
endmodule

// File: tb/tb_w_serial_loader.sv
// tb_w_serial_loader: directed and randomized frames checked against a frame-level model.
// Set W_LOADER_PARITY_EN to exercise the parity build.
module tb_w_serial_loader;
  localparam int WW = 13;
  localparam int S  = 2;
`ifdef W_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = WW + PAR;
  logic clk = 1'b0;
  logic reset, en, sclk, sdata, cs_n;
  logic [WW-1:0] W;
  logic W_valid, frame_err, busy;
  int n_chk = 0, n_fail = 0, n_vld = 0, n_err = 0, exp_vld = 0, exp_err = 0, busy_bad = 0, lat = 0;
  logic [WW-1:0] exp_w = '0;
  logic [WW-1:0] cq[$];
  bit in_frame = 1'b0;
  always #5 clk = ~clk;
  w_serial_loader #(.W_WIDTH(WW), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .en(en), .sclk(sclk), .sdata(sdata), .cs_n(cs_n),
    .W(W), .W_valid(W_valid), .frame_err(frame_err), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (W_valid) begin
      n_vld++;
      cq.push_back(W);
    end
    if (frame_err) n_err++;
    if (W_valid || frame_err) check("excl", {31'b0, W_valid & frame_err}, 32'd0);
    if (in_frame && !busy) busy_bad++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] mk(input logic [WW-1:0] w);
    return PAR != 0 ? 16'({w, ~^w}) : 16'(w);
  endfunction
  // frame-level model: length must be FB, and with parity the XOR of all bits must be 1
  task automatic model(input logic [15:0] bits, input int n);
    logic [15:0] m;
    bit ok;
    m  = bits & 16'((17'h1 << n) - 1);
    ok = (n == FB) && (PAR == 0 || (^m) == 1'b1);
    if (ok) begin
      exp_w = WW'(m >> PAR);
      exp_vld++;
    end else exp_err++;
  endtask
  task automatic send(input logic [15:0] bits, input int n, input int abort_after, input int hold);
    bit aborted = 1'b0;
    cs_n = 1'b0;
    tick(4);
    in_frame = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        in_frame = 1'b0;
        aborted  = 1'b1;
        en       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        tick(1);
      end
      sdata = bits[n-1-i];
      tick(2);
      sclk = 1'b1;
      tick(2);
      sclk = 1'b0;
    end
    tick(2);
    in_frame = 1'b0;
    cs_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (lat == 0 && (W_valid || frame_err)) lat = k;
    end
    @(posedge clk);
    #1;
    if (!aborted) model(bits, n);
    en = 1'b1;
  endtask
  task automatic verdict(input string tag);
    check({tag, "_w"}, 32'(W), 32'(exp_w));
    check({tag, "_vld"}, n_vld, exp_vld);
    check({tag, "_err"}, n_err, exp_err);
  endtask
  initial begin
    reset = 1'b1; en = 1'b1; sclk = 1'b0; sdata = 1'b0; cs_n = 1'b1;
    tick(3);
    check("rst_w", 32'(W), 32'd0);
    check("rst_vld", {31'b0, W_valid}, 32'd0);
    check("rst_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    tick(2);
    busy_bad = 0;
    send(mk(13'h1ABC), FB, -1, S + 3);
    check("lat", lat, S + 1);
    check("busy_frame", busy_bad, 0);
    verdict("first");
    check("first_val", 32'(W), 32'h1ABC);
    send(16'hABC, FB - 1, -1, S + 3);
    verdict("short");
    send(16'h2ABC, FB + 1, -1, S + 3);
    verdict("long");
    check("keep_w", 32'(W), 32'h1ABC);
`ifdef W_LOADER_PARITY_EN
    send(16'h0002, FB, -1, S + 3);
    verdict("par_good");
    check("par_good_val", 32'(W), 32'h0001);
    send(16'h0003, FB, -1, S + 3);
    verdict("par_bad");
    check("par_bad_val", 32'(W), 32'h0001);
`endif
    send(mk(13'h0123), FB, 6, S + 3);
    verdict("abort");
    send(mk(13'h0055), FB, -1, S + 3);
    verdict("after_abort");
    check("after_abort_val", 32'(W), 32'h0055);
    cq.delete();
    send(mk(13'h1FFF), FB, -1, 1);
    send(mk(13'h0000), FB, -1, S + 3);
    verdict("b2b");
    check("b2b_n", cq.size(), 2);
    if (cq.size() == 2) begin
      check("b2b_0", 32'(cq[0]), 32'h1FFF);
      check("b2b_1", 32'(cq[1]), 32'h0000);
    end
    for (int r = 0; r < 40; r++) begin
      int sel, n, ab;
      sel = $urandom_range(0, 3);
      n   = sel == 0 ? FB - 1 : sel == 1 ? FB + 1 : FB;
      ab  = $urandom_range(0, 7) == 0 ? $urandom_range(1, n - 2) : -1;
      send(16'($urandom), n, ab, S + 3);
      verdict("rnd");
    end
    send(mk(13'h0AAA), FB, -1, S + 3);
    verdict("pre_rst");
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      sdata = i[0];
      tick(2);
      sclk = 1'b1;
      tick(2);
      sclk = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_w", 32'(W), 32'd0);
    check("mrst_vld", {31'b0, W_valid}, 32'd0);
    check("mrst_err", {31'b0, frame_err}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    cs_n = 1'b1;
    sclk = 1'b0;
    tick(3);
    reset = 1'b0;
    exp_w = '0;
    tick(8);
    verdict("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
